sr_ff_bank_sequencer: RTL and testbench



---
 rtl/sr_ff_bank_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_sr_ff_bank_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_bank_sequencer.sv
// Round-robin sequencer sharing one SR flip-flop bank among several requesters.
// Define SRSEQ_RETRY_EN to re-pulse once after a readback mismatch.
module sr_ff_bank_sequencer #(
  parameter int unsigned  N_REQ     = 4,
  parameter int unsigned  N_FF      = 8,
  parameter int unsigned  IDX_W     = 3,
  parameter int unsigned  PULSE_CYC = 1,
  localparam int unsigned ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       op,
  input  logic [N_REQ*IDX_W-1:0] idx,
  output logic [N_REQ-1:0]       gnt,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic                   err,
  output logic [N_FF-1:0]        s_out,
  output logic [N_FF-1:0]        r_out,
  input  logic [N_FF-1:0]        q_in
);

  typedef enum logic [1:0] {StIdle, StDrive, StSettle, StCheck} state_e;

  localparam logic [3:0] CntLoad = 4'(PULSE_CYC - 1);

  state_e            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_rr, w_rr_nxt;
  logic [ID_W-1:0]   r_id, w_id_nxt;
  logic              r_op, w_op_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic              r_done, w_done_nxt;
  logic [ID_W-1:0]   r_done_id, w_done_id_nxt;
  logic              r_err, w_err_nxt;
  logic [N_FF-1:0]   r_s_out, w_s_nxt;
  logic [N_FF-1:0]   r_r_out, w_r_nxt;

  logic              w_found;
  logic [ID_W-1:0]   w_sel;
  logic              w_sel_op;
  logic [IDX_W-1:0]  w_sel_idx;
  logic              w_sel_legal;
  logic [N_FF-1:0]   w_sel_mask;
  logic [N_FF-1:0]   w_mask;
  logic              w_illegal;
  logic              w_mismatch;
  logic              w_retry;

  // First requester at or after the rr pointer, wrapping.
  always_comb begin
    int unsigned k;
    k         = 0;
    w_found   = 1'b0;
    w_sel     = '0;
    w_sel_op  = 1'b0;
    w_sel_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = (32'(r_rr) + i) % N_REQ;
      if (!w_found && req[k]) begin
        w_found   = 1'b1;
        w_sel     = ID_W'(k);
        w_sel_op  = op[k];
        w_sel_idx = idx[k*IDX_W +: IDX_W];
      end
    end
  end

  assign w_sel_legal = (32'(w_sel_idx) < N_FF);
  assign w_sel_mask  = N_FF'(1) << w_sel_idx;
  assign w_mask      = N_FF'(1) << r_idx;
  assign w_illegal   = (32'(r_idx) >= N_FF);
  assign w_mismatch  = ((|(q_in & w_mask)) != r_op);

`ifdef SRSEQ_RETRY_EN
  logic r_retried;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retried <= 1'b0;
    end else if (r_state == StIdle) begin
      r_retried <= 1'b0;
    end else if (r_state == StCheck) begin
      r_retried <= 1'b1;
    end
  end

  assign w_retry = ~w_illegal & w_mismatch & ~r_retried;
`else
  assign w_retry = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_rr_nxt      = r_rr;
    w_id_nxt      = r_id;
    w_op_nxt      = r_op;
    w_idx_nxt     = r_idx;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = '0;
    w_done_nxt    = 1'b0;
    w_done_id_nxt = '0;
    w_err_nxt     = 1'b0;
    w_s_nxt       = '0;
    w_r_nxt       = '0;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_id_nxt  = w_sel;
          w_op_nxt  = w_sel_op;
          w_idx_nxt = w_sel_idx;
          w_gnt_nxt = N_REQ'(1) << w_sel;
          w_rr_nxt  = (w_sel == ID_W'(N_REQ - 1)) ? '0 : w_sel + 1'b1;
          if (w_sel_legal) begin
            w_state_nxt = StDrive;
            w_cnt_nxt   = CntLoad;
            w_s_nxt     = w_sel_op ? w_sel_mask : '0;
            w_r_nxt     = w_sel_op ? '0 : w_sel_mask;
          end else begin
            w_state_nxt = StCheck;
          end
        end
      end
      StDrive: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = StSettle;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          w_s_nxt   = r_s_out;
          w_r_nxt   = r_r_out;
        end
      end
      StSettle: w_state_nxt = StCheck;
      StCheck: begin
        if (w_retry) begin
          w_state_nxt = StDrive;
          w_cnt_nxt   = CntLoad;
          w_s_nxt     = r_op ? w_mask : '0;
          w_r_nxt     = r_op ? '0 : w_mask;
        end else begin
          w_state_nxt   = StIdle;
          w_done_nxt    = 1'b1;
          w_done_id_nxt = r_id;
          w_err_nxt     = w_illegal | w_mismatch;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_rr      <= '0;
      r_id      <= '0;
      r_op      <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_err     <= 1'b0;
      r_s_out   <= '0;
      r_r_out   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr      <= w_rr_nxt;
      r_id      <= w_id_nxt;
      r_op      <= w_op_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_done    <= w_done_nxt;
      r_done_id <= w_done_id_nxt;
      r_err     <= w_err_nxt;
      r_s_out   <= w_s_nxt;
      r_r_out   <= w_r_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign done_id = r_done_id;
  assign err     = r_err;
  assign s_out   = r_s_out;
  assign r_out   = r_r_out;

endmodule

// File: tb/tb_sr_ff_bank_sequencer.sv
// Directed bench for sr_ff_bank_sequencer: one PULSE_CYC=1 instance and one PULSE_CYC=3 instance,
// each driving an ideal SR bank model.
module tb_sr_ff_bank_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0, op = '0, req3 = '0, op3 = '0;
  logic [15:0] idx = '0, idx3 = '0;

  logic [3:0]  gnt1, gnt3;
  logic        done1, done3, err1, err3;
  logic [1:0]  done_id1, done_id3;
  logic [7:0]  s1, r1, s3, r3;
  logic [7:0]  q1 = '0, q3 = '0, stuck1 = '0, pval3 = '0;
  logic        preset3 = 1'b0;
  logic [7:0]  qin1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Ideal bank models; stuck1 forces cells of the first bank to read 0.
  always @(posedge clk) q1 <= (q1 | s1) & ~r1;
  always @(posedge clk) begin
    if (preset3) q3 <= pval3;
    else         q3 <= (q3 | s3) & ~r3;
  end
  assign qin1 = q1 & ~stuck1;

  sr_ff_bank_sequencer #(.N_REQ(4), .N_FF(8), .IDX_W(4), .PULSE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx), .gnt(gnt1), .done(done1),
    .done_id(done_id1), .err(err1), .s_out(s1), .r_out(r1), .q_in(qin1)
  );

  sr_ff_bank_sequencer #(.N_REQ(4), .N_FF(8), .IDX_W(4), .PULSE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .op(op3), .idx(idx3), .gnt(gnt3), .done(done3),
    .done_id(done_id3), .err(err3), .s_out(s3), .r_out(r3), .q_in(q3)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_gnt", 32'(gnt1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_done_id", 32'(done_id1), 0);
    chk("rst_err", 32'(err1), 0);
    chk("rst_s", 32'(s1), 0);
    chk("rst_r", 32'(r1), 0);
    chk("rst_gnt3", 32'(gnt3), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_gnt", 32'(gnt1), 0);

    // 1: single set of cell 3
    req = 4'b0001; op = 4'b0001; idx = 16'h0003;
    tick();
    chk("t1_gnt", 32'(gnt1), 32'h1);
    chk("t1_s", 32'(s1), 32'h08);
    chk("t1_r", 32'(r1), 0);
    req = '0;
    tick();
    chk("t1_s_off", 32'(s1), 0);
    chk("t1_gnt_off", 32'(gnt1), 0);
    tick();
    chk("t1_done_early", 32'(done1), 0);
    tick();
    chk("t1_done", 32'(done1), 1);
    chk("t1_done_id", 32'(done_id1), 0);
    chk("t1_err", 32'(err1), 0);

    // 2: round robin with all four requesting
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 4'hF; op = 4'hF; idx = 16'h7654;
    tick();
    for (int g = 0; g < 4; g++) begin
      chk("rr_gnt", 32'(gnt1), 32'(1) << g);
      req[g] = 1'b0;
      tick();
      chk("rr_gnt_gap", 32'(gnt1), 0);
      tick(); tick();
      chk("rr_done", 32'(done1), 1);
      chk("rr_done_id", 32'(done_id1), 32'(g));
      chk("rr_err", 32'(err1), 0);
      if (g == 3) req = 4'b0001;
      tick();
    end
    chk("rr_wrap", 32'(gnt1), 32'h1);
    req = '0;
    tick(); tick(); tick();

    // 3: clear with PULSE_CYC=3, cell preset to 1
    pval3 = 8'h20; preset3 = 1'b1;
    tick();
    preset3 = 1'b0;
    req3 = 4'b0100; op3 = 4'b0000; idx3 = 16'h0500;
    tick();
    chk("t3_gnt", 32'(gnt3), 32'h4);
    chk("t3_r0", 32'(r3), 32'h20);
    chk("t3_s", 32'(s3), 0);
    req3 = '0;
    tick();
    chk("t3_r1", 32'(r3), 32'h20);
    tick();
    chk("t3_r2", 32'(r3), 32'h20);
    tick();
    chk("t3_r_end", 32'(r3), 0);
    tick();
    chk("t3_done_early", 32'(done3), 0);
    tick();
    chk("t3_done", 32'(done3), 1);
    chk("t3_done_id", 32'(done_id3), 2);
    chk("t3_err", 32'(err3), 0);

    // 4: illegal index 9
    req = 4'b0010; op = 4'b0010; idx = 16'h0090;
    tick();
    chk("t4_gnt", 32'(gnt1), 32'h2);
    chk("t4_s", 32'(s1), 0);
    chk("t4_r", 32'(r1), 0);
    chk("t4_done_early", 32'(done1), 0);
    req = '0;
    tick();
    chk("t4_done", 32'(done1), 1);
    chk("t4_err", 32'(err1), 1);
    chk("t4_done_id", 32'(done_id1), 1);
    chk("t4_s_after", 32'(s1), 0);
    tick();

    // 5: cell 1 stuck at 0
    stuck1 = 8'h02;
    req = 4'b0001; op = 4'b0001; idx = 16'h0001;
    tick();
    chk("t5_gnt", 32'(gnt1), 32'h1);
    chk("t5_s", 32'(s1), 32'h02);
    req = '0;
    tick();
    chk("t5_s_off", 32'(s1), 0);
    tick();
`ifdef SRSEQ_RETRY_EN
    tick();
    chk("t5_no_done", 32'(done1), 0);
    chk("t5_retry_s", 32'(s1), 32'h02);
    tick(); tick(); tick();
`else
    tick();
`endif
    chk("t5_done", 32'(done1), 1);
    chk("t5_err", 32'(err1), 1);
    chk("t5_done_id", 32'(done_id1), 0);
    tick();
    stuck1 = '0;

    // 6: async reset during DRIVE
    req = 4'b0001; op = 4'b0001; idx = 16'h0002;
    tick();
    chk("t6_s", 32'(s1), 32'h04);
    req = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_s", 32'(s1), 0);
    chk("t6_async_gnt", 32'(gnt1), 0);
    tick();
    chk("t6_no_done0", 32'(done1), 0);
    tick();
    chk("t6_no_done1", 32'(done1), 0);
    rst_n = 1'b1;
    req = 4'b0011; op = 4'b0011; idx = 16'h0010;
    tick();
    chk("t6_rr_reset", 32'(gnt1), 32'h1);
    req = '0;
    tick(); tick(); tick();
    chk("t6_done", 32'(done1), 1);
    chk("t6_done_id", 32'(done_id1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
